// File: rtl/piso_shift_ctrl.sv
// -----------------------------------------------------------------------------
// piso_shift_ctrl
//
// Parallel-in serial-out shift stage. An upstream agent hands over a WIDTH-bit
// word with a valid/ready handshake. A downstream agent then pulls the word out
// one bit per cycle in which shift_en is high, MSB-first or LSB-first. The bit
// order is chosen by lsb_first at the moment the word is accepted.
//
// Build option:
//   PISO_BACKTOBACK_EN - when defined, a new word may be accepted in the same
//                        cycle that the final bit of the current word is
//                        consumed. This gives zero-bubble streaming. When it is
//                        undefined, a word is accepted only in IDLE.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   load_valid in   upstream presents load_data
//   load_ready out  a word is accepted this cycle if load_valid is high
//   load_data  in   [WIDTH-1:0] parallel word to serialise
//   lsb_first  in   bit order, sampled only on an accepted load (1 = LSB first)
//   shift_en   in   downstream consumes the current sout bit this cycle
//   sout       out  current serial bit (0 when idle)
//   sout_valid out  sout holds a valid bit
//   last       out  sout is the final bit of the word
//   busy       out  a word is being serialised
// -----------------------------------------------------------------------------
module piso_shift_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [WIDTH-1:0] shl_word, shr_word;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             in_shift;
    logic             advance;
    logic             accept;

    assign in_shift = (state_reg == SHIFT);
    assign last     = in_shift && (cnt_reg == CW'(WIDTH - 1));
    assign advance  = in_shift && shift_en;

`ifdef PISO_BACKTOBACK_EN
    // A load also fits into the cycle that retires the final bit.
    assign load_ready = !in_shift || (last && shift_en);
`else
    assign load_ready = !in_shift;
`endif

    assign accept     = load_valid && load_ready;
    assign busy       = in_shift;
    assign sout_valid = in_shift;
    // sout is forced low in IDLE so that no leftover bits from a finished or
    // discarded word appear on the output.
    assign sout       = in_shift && (dir_reg ? shreg_reg[0] : shreg_reg[WIDTH-1]);

    // Shift candidates. The vacated end is filled with zero.
    assign shl_word = {shreg_reg[WIDTH-2:0], 1'b0};
    assign shr_word = {1'b0, shreg_reg[WIDTH-1:1]};

    // Per-bit 2:1 select: load vs shift. Hold when neither applies.
    // Load takes priority, so a back-to-back reload overrides the last shift.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign shreg_next[gi] = accept  ? load_data[gi] :
                                    advance ? (dir_reg ? shr_word[gi] : shl_word[gi]) :
                                              shreg_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        if (accept) begin
            state_next = SHIFT;
            cnt_next   = '0;
            dir_next   = lsb_first;
        end else if (advance) begin
            if (last) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
        end
    end

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_ctrl
//
// Scoreboard bench for piso_shift_ctrl (WIDTH = 8).
//
// When a word is handed to the DUT, the expected bit stream and the expected
// last flags are pushed onto queues. Each bit the DUT consumes pops one entry
// from each queue and compares against it.
//
// Inputs are driven at posedge+1. Outputs are sampled at posedge+2.
// -----------------------------------------------------------------------------
module tb_piso_shift_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_data = '0;
    logic         lsb_first = 1'b0;
    logic         shift_en = 1'b0;
    logic         sout;
    logic         sout_valid;
    logic         last;
    logic         busy;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    logic exp_last_q[$];

    always #5 clk = ~clk;

    piso_shift_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .lsb_first  (lsb_first),
        .shift_en   (shift_en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (last),
        .busy       (busy)
    );

    // Reference model: the expected serial order of a word.
    task automatic push_word(input logic [W-1:0] d, input logic lsb);
        for (int i = 0; i < W; i++) begin
            exp_q.push_back(lsb ? d[i] : d[W-1-i]);
            exp_last_q.push_back(i == W - 1);
        end
    endtask

    // Offer a word while the DUT is idle. The task returns at posedge+1, with
    // the first bit already on sout.
    task automatic load_word(input logic [W-1:0] d, input logic lsb);
        shift_en   = 1'b1;
        load_valid = 1'b1;
        load_data  = d;
        lsb_first  = lsb;
        @(posedge clk);
        push_word(d, lsb);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({sout, sout_valid, last, busy, load_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00001", {sout, sout_valid, last, busy, load_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Toggling shift_en while idle must be ignored.
        shift_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({sout, sout_valid, last, busy, load_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=00001", {sout, sout_valid, last, busy, load_ready});
        end
        $display("test_reset done");
    endtask

    task automatic test_msb_first();
        logic e, el;
        load_word(8'h1E, 1'b0);
        for (int cyc = 0; cyc < 4 * W && exp_q.size() > 0; cyc++) begin
            #1;
            checks++;
            if (sout_valid !== 1'b1) begin
                failures++;
                $display("FAIL msb_valid cyc=%0d got=%b exp=1", cyc, sout_valid);
            end else begin
                e  = exp_q.pop_front();
                el = exp_last_q.pop_front();
                checks++;
                if (sout !== e) begin
                    failures++;
                    $display("FAIL msb_bit cyc=%0d got=%b exp=%b", cyc, sout, e);
                end
                checks++;
                if (last !== el) begin
                    failures++;
                    $display("FAIL msb_last cyc=%0d got=%b exp=%b", cyc, last, el);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL msb_timeout left=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
        exp_last_q.delete();
        #1;
        checks++;
        if ({busy, sout_valid, load_ready} !== 3'b001) begin
            failures++;
            $display("FAIL msb_end_idle got=%b exp=001", {busy, sout_valid, load_ready});
        end
        $display("test_msb_first done");
    endtask

    task automatic test_lsb_first();
        logic e, el;
        load_word(8'h1E, 1'b1);
        for (int cyc = 0; cyc < 4 * W && exp_q.size() > 0; cyc++) begin
            // A lsb_first change mid-word must not affect the word in flight.
            if (cyc == 3) lsb_first = 1'b0;
            #1;
            checks++;
            if (sout_valid !== 1'b1) begin
                failures++;
                $display("FAIL lsb_valid cyc=%0d got=%b exp=1", cyc, sout_valid);
            end else begin
                e  = exp_q.pop_front();
                el = exp_last_q.pop_front();
                checks++;
                if (sout !== e) begin
                    failures++;
                    $display("FAIL lsb_bit cyc=%0d got=%b exp=%b", cyc, sout, e);
                end
                checks++;
                if (last !== el) begin
                    failures++;
                    $display("FAIL lsb_last cyc=%0d got=%b exp=%b", cyc, last, el);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL lsb_timeout left=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
        exp_last_q.delete();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL lsb_end_busy got=%b exp=0", busy);
        end
        $display("test_lsb_first done");
    endtask

    task automatic test_stall_ignore();
        logic e, el;
        int   pops  = 0;
        int   stall = 0;
        load_word(8'hA5, 1'b0);
        for (int cyc = 0; cyc < 4 * W && exp_q.size() > 0; cyc++) begin
            if (pops == 2 && stall < 3) begin
                // Stall for three cycles while offering a word that must be ignored.
                shift_en   = 1'b0;
                load_valid = 1'b1;
                load_data  = 8'hFF;
                #1;
                checks++;
                if ({sout_valid, sout} !== {1'b1, exp_q[0]}) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout}, {1'b1, exp_q[0]});
                end
                checks++;
                if (load_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_ready cyc=%0d got=%b exp=0", cyc, load_ready);
                end
                stall++;
            end else begin
                shift_en   = 1'b1;
                load_valid = 1'b0;
                #1;
                checks++;
                if (sout_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_valid cyc=%0d got=%b exp=1", cyc, sout_valid);
                end else begin
                    e  = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    pops++;
                    checks++;
                    if (sout !== e) begin
                        failures++;
                        $display("FAIL stall_bit cyc=%0d got=%b exp=%b", cyc, sout, e);
                    end
                    checks++;
                    if (last !== el) begin
                        failures++;
                        $display("FAIL stall_last cyc=%0d got=%b exp=%b", cyc, last, el);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_timeout left=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
        exp_last_q.delete();
        #1;
        checks++;
        if (sout_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_capture got=%b exp=0", sout_valid);
        end
        $display("test_stall_ignore done");
    endtask

    task automatic test_reset_mid_word();
        logic e, el;
        load_word(8'hF0, 1'b0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            checks++;
            if ({sout_valid, sout} !== {1'b1, e}) begin
                failures++;
                $display("FAIL rmid_bit cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout}, {1'b1, e});
            end
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        exp_last_q.delete();
        shift_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        // Reset must take effect before the next clock edge.
        checks++;
        if ({sout, sout_valid, last, busy, load_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL rmid_async got=%b exp=00001", {sout, sout_valid, last, busy, load_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sout_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_discard got=%b exp=0", sout_valid);
        end
        load_word(8'h81, 1'b0);
        for (int cyc = 0; cyc < 4 * W && exp_q.size() > 0; cyc++) begin
            #1;
            checks++;
            if (sout_valid !== 1'b1) begin
                failures++;
                $display("FAIL rmid_valid cyc=%0d got=%b exp=1", cyc, sout_valid);
            end else begin
                e  = exp_q.pop_front();
                el = exp_last_q.pop_front();
                checks++;
                if ({sout, last} !== {e, el}) begin
                    failures++;
                    $display("FAIL rmid_word cyc=%0d got=%b exp=%b", cyc, {sout, last}, {e, el});
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rmid_timeout left=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
        exp_last_q.delete();
        $display("test_reset_mid_word done");
    endtask

    task automatic test_back_to_back();
        logic e, el;
        logic accept_now;
        logic offer_checked = 1'b0;
        logic accepted2     = 1'b0;
        int   gap           = 0;
`ifdef PISO_BACKTOBACK_EN
        int   gap_exp       = 0;
        logic ready_exp     = 1'b1;
`else
        int   gap_exp       = 1;
        logic ready_exp     = 1'b0;
`endif
        @(posedge clk);
        #1;
        load_word(8'h1E, 1'b0);
        for (int cyc = 0; cyc < 6 * W && (exp_q.size() > 0 || !accepted2); cyc++) begin
            shift_en = 1'b1;
            if (!accepted2 && exp_q.size() <= 1) begin
                load_valid = 1'b1;
                load_data  = 8'hE1;
                lsb_first  = 1'b0;
            end
            #1;
            if (sout_valid === 1'b1) begin
                e  = exp_q.pop_front();
                el = exp_last_q.pop_front();
                checks++;
                if ({sout, last} !== {e, el}) begin
                    failures++;
                    $display("FAIL b2b_bit cyc=%0d got=%b exp=%b", cyc, {sout, last}, {e, el});
                end
            end else begin
                gap++;
            end
            if (load_valid && !offer_checked) begin
                // The first offer coincides with the final bit of word one.
                offer_checked = 1'b1;
                checks++;
                if (load_ready !== ready_exp) begin
                    failures++;
                    $display("FAIL b2b_ready_at_last got=%b exp=%b", load_ready, ready_exp);
                end
            end
            accept_now = load_valid && load_ready;
            @(posedge clk);
            if (accept_now) begin
                push_word(8'hE1, 1'b0);
                accepted2  = 1'b1;
            end
            #1;
            if (accept_now) load_valid = 1'b0;
        end
        load_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || !accepted2) begin
            failures++;
            $display("FAIL b2b_timeout left=%0d accepted=%b exp=0/1", exp_q.size(), accepted2);
        end
        checks++;
        if (gap != gap_exp) begin
            failures++;
            $display("FAIL b2b_gap got=%0d exp=%0d", gap, gap_exp);
        end
        exp_q.delete();
        exp_last_q.delete();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end_busy got=%b exp=0", busy);
        end
        $display("test_back_to_back done gap=%0d", gap);
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall_ignore();
        test_reset_mid_word();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
